// File: rtl/diag_ebus_pkg.sv
// Shared types and constants for the EBUS diagnostic-cycle master.
package diag_ebus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    WAIT    = 3'd4,
    CAPTURE = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Octal function groups (function code bits 0:5) with dedicated decodes
  localparam logic [5:0] FUNC_GRP_LOAD_06X = 6'o06;
  localparam logic [5:0] FUNC_GRP_READ_13X = 6'o13;

  // Width of the shared phase/timeout counter
  localparam int CNT_W = 8;

  // Odd-parity check over data plus parity bit: 1 when the total count of ones is even
  function automatic logic odd_par_err(input logic [0:35] data, input logic par);
    return ~^{data, par};
  endfunction

endpackage

// File: rtl/diag_ebus_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and WAIT phases.
// 'expired' is high while the count sits at zero.
module diag_ebus_timer
  import diag_ebus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count_r;

  // Reload on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/diag_ebus_master.sv
// EBUS diagnostic-function initiator: accepts one console request at a time,
// presents the function code, strobes it, and either holds write data on EBUS
// or waits (with timeout) for a responder and captures its data.
// All outputs are registered from the next-state decode so they track the
// FSM state without combinational glitches.
// Optional build macro: DIAG_EBUS_PARITY_EN adds ebusParIn, rspParErr and
// busConflict (parity check on captured data, sticky bus-contention flag).
module diag_ebus_master
  import diag_ebus_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        eboxClk,
  input  logic        eboxResetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [0:8]  reqFunc,
  input  logic [0:35] reqData,
  output logic        rspValid,
  output logic [0:35] rspData,
  output logic        rspTimeout,
  output logic [0:8]  diagFunc,
  output logic        diagStrobe,
  output logic        diagLoadFunc06X,
  output logic        diagReadFunc13X,
  output logic [0:35] ebusDataOut,
  output logic        ebusDriveEn,
  input  logic [0:35] ebusDataIn,
  input  logic        ebusResponderDrv
`ifdef DIAG_EBUS_PARITY_EN
  ,
  input  logic        ebusParIn,
  output logic        rspParErr,
  output logic        busConflict
`endif
);

  state_t           state_r;
  state_t           state_s;

  logic             hold_write_r;
  logic [0:8]       hold_func_r;
  logic [0:35]      hold_data_r;

  // Request fields as they will be seen in the upcoming state
  logic             nxt_write_s;
  logic [0:8]       nxt_func_s;
  logic [0:35]      nxt_data_s;
  logic             accept_s;

  logic             timer_load_s;
  logic [CNT_W-1:0] timer_val_s;
  logic             timer_expired_s;

  logic             ready_s;
  logic [0:8]       func_s;
  logic             strobe_s;
  logic             load06_s;
  logic             read13_s;
  logic             drive_s;
  logic [0:35]      data_out_s;
  logic             rsp_valid_s;
  logic             rsp_timeout_s;
  logic [0:35]      rsp_data_s;
`ifdef DIAG_EBUS_PARITY_EN
  logic             rsp_par_err_s;
`endif

  diag_ebus_timer u_timer (
    .clk      (eboxClk),
    .rst_n    (eboxResetN),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .expired  (timer_expired_s)
  );

  assign accept_s = (state_r == IDLE) && reqValid;

  // State register
  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request holding registers, loaded only on acceptance in IDLE
  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      hold_write_r <= 1'b0;
      hold_func_r  <= 9'o000;
      hold_data_r  <= 36'o0;
    end else if (accept_s) begin
      hold_write_r <= reqWrite;
      hold_func_r  <= reqFunc;
      hold_data_r  <= reqData;
    end else begin
      hold_write_r <= hold_write_r;
      hold_func_r  <= hold_func_r;
      hold_data_r  <= hold_data_r;
    end
  end

  // Next-state logic and phase-timer reload on every state change
  always_comb begin
    state_s     = state_r;
    timer_val_s = {CNT_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (reqValid) state_s = SETUP;
        else          state_s = IDLE;
      end
      SETUP: begin
        if (timer_expired_s) state_s = STROBE;
        else                 state_s = SETUP;
      end
      STROBE: begin
        if (timer_expired_s) begin
          if (hold_write_r) state_s = HOLD;
          else              state_s = WAIT;
        end else begin
          state_s = STROBE;
        end
      end
      HOLD:    state_s = DONE;
      WAIT: begin
        // A responder seen on the last counted cycle still wins over timeout
        if (ebusResponderDrv)     state_s = CAPTURE;
        else if (timer_expired_s) state_s = DONE;
        else                      state_s = WAIT;
      end
      CAPTURE: state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    case (state_s)
      SETUP:   timer_val_s = CNT_W'(SETUP_CYC - 1);
      STROBE:  timer_val_s = CNT_W'(STROBE_CYC - 1);
      WAIT:    timer_val_s = CNT_W'(TIMEOUT_CYC - 1);
      default: timer_val_s = {CNT_W{1'b0}};
    endcase
    timer_load_s = (state_s != state_r);
  end

  // Output decode for the upcoming state, registered below
  always_comb begin
    if (accept_s) begin
      nxt_write_s = reqWrite;
      nxt_func_s  = reqFunc;
      nxt_data_s  = reqData;
    end else begin
      nxt_write_s = hold_write_r;
      nxt_func_s  = hold_func_r;
      nxt_data_s  = hold_data_r;
    end
    ready_s       = 1'b0;
    func_s        = 9'o000;
    strobe_s      = 1'b0;
    drive_s       = 1'b0;
    read13_s      = 1'b0;
    rsp_valid_s   = 1'b0;
    rsp_timeout_s = 1'b0;
    case (state_s)
      IDLE: begin
        ready_s = 1'b1;
      end
      SETUP: begin
        func_s   = nxt_func_s;
        drive_s  = nxt_write_s;
        read13_s = ~nxt_write_s;
      end
      STROBE: begin
        func_s   = nxt_func_s;
        strobe_s = 1'b1;
        drive_s  = nxt_write_s;
        read13_s = ~nxt_write_s;
      end
      HOLD: begin
        func_s  = nxt_func_s;
        drive_s = nxt_write_s;
      end
      WAIT, CAPTURE: begin
        func_s   = nxt_func_s;
        read13_s = ~nxt_write_s;
      end
      DONE: begin
        rsp_valid_s   = 1'b1;
        rsp_timeout_s = (state_r == WAIT);
      end
      default: begin
        ready_s = 1'b1;
      end
    endcase
    load06_s = strobe_s & nxt_write_s & (nxt_func_s[0:5] == FUNC_GRP_LOAD_06X);
    read13_s = read13_s & (nxt_func_s[0:5] == FUNC_GRP_READ_13X);
    if (drive_s) data_out_s = nxt_data_s;
    else         data_out_s = 36'o0;
    if (state_r == CAPTURE) rsp_data_s = ebusDataIn;
    else                    rsp_data_s = 36'o0;
`ifdef DIAG_EBUS_PARITY_EN
    if (rsp_valid_s && (state_r == CAPTURE)) rsp_par_err_s = odd_par_err(ebusDataIn, ebusParIn);
    else                                     rsp_par_err_s = 1'b0;
`endif
  end

  // Registered outputs; response data is only updated on entry to DONE
  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      reqReady        <= 1'b1;
      diagFunc        <= 9'o000;
      diagStrobe      <= 1'b0;
      diagLoadFunc06X <= 1'b0;
      diagReadFunc13X <= 1'b0;
      ebusDriveEn     <= 1'b0;
      ebusDataOut     <= 36'o0;
      rspValid        <= 1'b0;
      rspTimeout      <= 1'b0;
      rspData         <= 36'o0;
    end else begin
      reqReady        <= ready_s;
      diagFunc        <= func_s;
      diagStrobe      <= strobe_s;
      diagLoadFunc06X <= load06_s;
      diagReadFunc13X <= read13_s;
      ebusDriveEn     <= drive_s;
      ebusDataOut     <= data_out_s;
      rspValid        <= rsp_valid_s;
      rspTimeout      <= rsp_timeout_s;
      if (rsp_valid_s) rspData <= rsp_data_s;
      else             rspData <= rspData;
    end
  end

`ifdef DIAG_EBUS_PARITY_EN
  // Parity result qualified by rspValid, and sticky contention flag
  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      rspParErr   <= 1'b0;
      busConflict <= 1'b0;
    end else begin
      rspParErr <= rsp_par_err_s;
      if (ebusDriveEn && ebusResponderDrv) busConflict <= 1'b1;
      else                                 busConflict <= busConflict;
    end
  end
`endif

endmodule

// File: tb/tb_diag_ebus_master.sv
// Self-checking bench for diag_ebus_master: table of directed transactions,
// an asynchronous-reset sequence, then randomized transactions, all checked
// cycle by cycle against a cycle-index model of one transaction.
module tb_diag_ebus_master;

  localparam int S  = 2;
  localparam int T  = 3;
  localparam int TO = 64;

  logic        eboxClk = 1'b0;
  logic        eboxResetN;
  logic        reqValid, reqReady, reqWrite;
  logic [8:0]  reqFunc;
  logic [35:0] reqData;
  logic        rspValid, rspTimeout;
  logic [35:0] rspData;
  logic [8:0]  diagFunc;
  logic        diagStrobe, diagLoadFunc06X, diagReadFunc13X;
  logic [35:0] ebusDataOut;
  logic        ebusDriveEn;
  logic [35:0] ebusDataIn;
  logic        ebusResponderDrv;
  logic        ebusParIn;
`ifdef DIAG_EBUS_PARITY_EN
  logic        rspParErr, busConflict;
`endif

  diag_ebus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .TIMEOUT_CYC(TO)) dut (
    .eboxClk(eboxClk), .eboxResetN(eboxResetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqFunc(reqFunc), .reqData(reqData),
    .rspValid(rspValid), .rspData(rspData), .rspTimeout(rspTimeout),
    .diagFunc(diagFunc), .diagStrobe(diagStrobe),
    .diagLoadFunc06X(diagLoadFunc06X), .diagReadFunc13X(diagReadFunc13X),
    .ebusDataOut(ebusDataOut), .ebusDriveEn(ebusDriveEn),
    .ebusDataIn(ebusDataIn), .ebusResponderDrv(ebusResponderDrv)
`ifdef DIAG_EBUS_PARITY_EN
    , .ebusParIn(ebusParIn), .rspParErr(rspParErr), .busConflict(busConflict)
`endif
  );

  always #5 eboxClk = ~eboxClk;

  typedef struct packed {
    logic        ready, valid, timeout, strobe, drive, load06, read13, parerr, conflict;
    logic [35:0] rdata;
    logic [35:0] dout;
    logic [8:0]  func;
  } obs_t;

  typedef struct {
    string       name;
    logic        wr;
    logic [8:0]  func;
    logic [35:0] data;
    int          delay;     // WAIT cycles before responder drives; -1 = never
    logic [35:0] rd;
    logic        par;
    logic        hold;      // keep reqValid high into the next request
    int          exp_lat;
    logic [35:0] exp_rdata;
    logic        exp_to;
    logic        exp_perr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Model of the transaction in flight
  logic        m_wr, m_par;
  logic [8:0]  m_func;
  logic [35:0] m_data, m_rd;
  int          m_delay, m_lat;
  logic [35:0] m_prev_rdata = 36'd0;

  function automatic logic [35:0] rand36();
    return {4'($urandom_range(15, 0)), 32'($urandom)};
  endfunction

  function automatic logic m_responds();
    return !m_wr && m_delay >= 0 && m_delay < TO;
  endfunction

  function automatic int model_lat();
    if (m_wr)              return S + T + 2;
    else if (m_responds()) return S + T + 3 + m_delay;
    else                   return S + T + 1 + TO;
  endfunction

  function automatic logic resp_on(input int k);
    return m_responds() && k >= S + T + 1 + m_delay && k <= m_lat;
  endfunction

  // Expected outputs in cycle k after the acceptance cycle (k = 0)
  function automatic obs_t model_exp(input int k);
    obs_t e;
    logic timed;
    e = '0;
    timed     = !m_wr && !m_responds();
    e.ready   = (k > m_lat);
    e.valid   = (k == m_lat);
    e.timeout = (k == m_lat) && timed;
    e.strobe  = (k >= S + 1) && (k <= S + T);
    e.drive   = m_wr && (k >= 1) && (k <= S + T + 1);
    e.dout    = e.drive ? m_data : 36'd0;
    e.func    = (k >= 1 && k < m_lat) ? m_func : 9'd0;
    e.load06  = e.strobe && m_wr && (m_func[8:3] == 6'o06);
    e.read13  = !m_wr && (k >= 1) && (k < m_lat) && (m_func[8:3] == 6'o13);
    if (k >= m_lat) e.rdata = (m_wr || timed) ? 36'd0 : m_rd;
    else            e.rdata = m_prev_rdata;
`ifdef DIAG_EBUS_PARITY_EN
    e.parerr = (k == m_lat) && m_responds() && ($countones({m_rd, m_par}) % 2 == 0);
`endif
    return e;
  endfunction

  function automatic obs_t reset_obs();
    obs_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.ready = reqReady;     a.valid = rspValid;   a.timeout = rspTimeout;
    a.strobe = diagStrobe;  a.drive = ebusDriveEn;
    a.load06 = diagLoadFunc06X; a.read13 = diagReadFunc13X;
    a.rdata = rspData;      a.dout = ebusDataOut; a.func = diagFunc;
`ifdef DIAG_EBUS_PARITY_EN
    a.parerr = rspParErr;   a.conflict = busConflict;
`else
    a.parerr = 1'b0;        a.conflict = 1'b0;
`endif
    return a;
  endfunction

  task automatic check_obs(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s rdy/vld/to/stb/drv/06/13/perr/conf got=%b%b%b%b%b%b%b%b%b exp=%b%b%b%b%b%b%b%b%b rdata got=%o exp=%o dout got=%o exp=%o func got=%o exp=%o",
               name, a.ready, a.valid, a.timeout, a.strobe, a.drive, a.load06, a.read13, a.parerr, a.conflict,
               e.ready, e.valid, e.timeout, e.strobe, e.drive, e.load06, e.read13, e.parerr, e.conflict,
               a.rdata, e.rdata, a.dout, e.dout, a.func, e.func);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (o%o) exp=%0d (o%o)", name, got, got, exp, exp);
    end
  endtask

  // Runs one transaction from an IDLE negedge to the following IDLE negedge
  task automatic run_txn(input string name, input logic wr, input logic [8:0] func,
                         input logic [35:0] data, input int delay, input logic [35:0] rd,
                         input logic par, input logic hold,
                         output int obs_lat, output logic [35:0] obs_rdata,
                         output logic obs_to, output logic obs_perr);
    obs_t a;
    m_wr = wr; m_func = func; m_data = data; m_delay = delay; m_rd = rd; m_par = par;
    m_lat = model_lat();
    reqValid = 1'b1; reqWrite = wr; reqFunc = func; reqData = data;
    ebusResponderDrv = 1'b0; ebusDataIn = rand36(); ebusParIn = par;
    obs_lat = 0; obs_rdata = 36'd0; obs_to = 1'b0; obs_perr = 1'b0;
    for (int k = 1; k <= m_lat + 1; k++) begin
      @(negedge eboxClk);
      a = sample();
      check_obs($sformatf("%s k=%0d", name, k), a, model_exp(k));
      if (a.valid && obs_lat == 0) begin
        obs_lat = k; obs_rdata = a.rdata; obs_to = a.timeout; obs_perr = a.parerr;
      end
      if (k <= m_lat) begin
        // Busy: offered requests must be ignored, so scramble them
        reqValid = hold;
        reqWrite = 1'($urandom);
        reqFunc  = 9'($urandom);
        reqData  = rand36();
      end else begin
        reqValid = 1'b0;
      end
      ebusResponderDrv = resp_on(k);
      ebusDataIn       = resp_on(k) ? rd : rand36();
    end
    m_prev_rdata = (m_wr || !m_responds()) ? 36'd0 : m_rd;
  endtask

  function automatic vec_t mk(input string name, input logic wr, input logic [8:0] func,
                              input logic [35:0] data, input int delay, input logic [35:0] rd,
                              input logic par, input logic hold, input int exp_lat,
                              input logic [35:0] exp_rdata, input logic exp_to, input logic exp_perr);
    vec_t v;
    v.name = name; v.wr = wr; v.func = func; v.data = data; v.delay = delay; v.rd = rd;
    v.par = par; v.hold = hold; v.exp_lat = exp_lat; v.exp_rdata = exp_rdata;
    v.exp_to = exp_to; v.exp_perr = exp_perr;
    return v;
  endfunction

  // Watchdog: the run must never hang
  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int          lat;
    logic [35:0] rdat;
    logic        tmo, perr;
    obs_t        a;

    vecs[0] = mk("wr061",     1'b1, 9'o061, 36'o123456701234, 0,  36'o0,            1'b0, 1'b1, 7,  36'o0,            1'b0, 1'b0);
    vecs[1] = mk("rd131_d5",  1'b0, 9'o131, 36'o0,            5,  36'o777000111222, 1'b0, 1'b0, 13, 36'o777000111222, 1'b0, 1'b0);
    vecs[2] = mk("rd131_to",  1'b0, 9'o131, 36'o0,            -1, 36'o0,            1'b0, 1'b0, 70, 36'o0,            1'b1, 1'b0);
    vecs[3] = mk("rd_par1",   1'b0, 9'o555, 36'o0,            0,  36'o1,            1'b1, 1'b0, 8,  36'o1,            1'b0, 1'b1);
    vecs[4] = mk("rd_par0",   1'b0, 9'o555, 36'o0,            0,  36'o1,            1'b0, 1'b1, 8,  36'o1,            1'b0, 1'b0);
    vecs[5] = mk("rd_lastw",  1'b0, 9'o134, 36'o0,            63, 36'o525252525252, 1'b1, 1'b1, 71, 36'o525252525252, 1'b0, 1'b0);
    vecs[6] = mk("wr060_b2b", 1'b1, 9'o060, 36'o777777777777, 0,  36'o0,            1'b0, 1'b1, 7,  36'o0,            1'b0, 1'b0);
    vecs[7] = mk("wr_other",  1'b1, 9'o200, 36'o000000000001, 0,  36'o0,            1'b0, 1'b0, 7,  36'o0,            1'b0, 1'b0);

    eboxResetN = 1'b0;
    reqValid = 1'b0; reqWrite = 1'b0; reqFunc = 9'd0; reqData = 36'd0;
    ebusDataIn = 36'd0; ebusResponderDrv = 1'b0; ebusParIn = 1'b0;
    #12;
    check_obs("reset_state", sample(), reset_obs());
    @(negedge eboxClk);
    eboxResetN = 1'b1;
    @(negedge eboxClk);
    check_obs("idle_after_reset", sample(), reset_obs());

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].name, vecs[i].wr, vecs[i].func, vecs[i].data, vecs[i].delay,
              vecs[i].rd, vecs[i].par, vecs[i].hold, lat, rdat, tmo, perr);
      check_val({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].exp_lat));
      check_val({vecs[i].name, " rspData"}, 64'(rdat), 64'(vecs[i].exp_rdata));
      check_val({vecs[i].name, " rspTimeout"}, 64'(tmo), 64'(vecs[i].exp_to));
`ifdef DIAG_EBUS_PARITY_EN
      check_val({vecs[i].name, " rspParErr"}, 64'(perr), 64'(vecs[i].exp_perr));
`endif
    end

    // Asynchronous reset in the middle of a write strobe
    reqValid = 1'b1; reqWrite = 1'b1; reqFunc = 9'o061; reqData = 36'o123456701234;
    @(negedge eboxClk);
    reqValid = 1'b0;
    @(negedge eboxClk);
    @(negedge eboxClk);
    @(negedge eboxClk);
    a = sample();
    check_val("rst_mid strobe_before", 64'({a.strobe, a.load06, a.drive}), 64'(3'b111));
    #2;
    eboxResetN = 1'b0;
    #1;
    check_obs("rst_mid async_clear", sample(), reset_obs());
    @(negedge eboxClk);
    eboxResetN = 1'b1;
    m_prev_rdata = 36'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge eboxClk);
      check_obs($sformatf("rst_mid after k=%0d", k), sample(), reset_obs());
    end

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic        wr, par, hold;
      logic [5:0]  grp;
      int          dly, sel;
      sel = $urandom_range(0, 2);
      grp = (sel == 0) ? 6'o06 : (sel == 1) ? 6'o13 : 6'($urandom);
      wr   = 1'($urandom);
      par  = 1'($urandom);
      hold = 1'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      dly = -1;
      else if (sel == 1) dly = $urandom_range(60, 70);
      else               dly = $urandom_range(0, 8);
      run_txn($sformatf("rand%0d", n), wr, {grp, 3'($urandom)}, rand36(), dly, rand36(),
              par, hold, lat, rdat, tmo, perr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
